arch_dump_unit: RTL and testbench

ARCH_DUMP_UNIT -- requirements
Module: arch_dump_unit

---
 rtl/arch_dump_pkg.sv | 26 ++
 rtl/sat_counter.sv | 19 +
 rtl/arch_dump_unit.sv | 117 +++++++++++
 tb/tb_arch_dump_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arch_dump_pkg.sv
// rtl/arch_dump_pkg.sv - shared types and constants for the architectural register dump unit
package arch_dump_pkg;

  localparam int ARCH_REG_W = 5;

  // Record container sized for the widest supported configuration; the top narrows each field.
  localparam int REC_PREG_W = 16;
  localparam int REC_DATA_W = 64;
  localparam int REC_TAG_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAP  = 2'd1,
    PRF  = 2'd2,
    SEND = 2'd3
  } state_t;

  typedef struct packed {
    logic [ARCH_REG_W-1:0] areg;
    logic [REC_PREG_W-1:0] preg;
    logic [REC_DATA_W-1:0] data;
    logic [REC_TAG_W-1:0]  tag;
    logic                  last;
  } dump_rec_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for the mispredict count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/arch_dump_unit.sv
// rtl/arch_dump_unit.sv - streams watched arch registers (rename map + PRF value) as records
// Define ARCH_DUMP_MISPRED_TRIG_EN to make every mispredict pulse also trigger a dump.
module arch_dump_unit
  import arch_dump_pkg::*;
#(
  parameter int NUM_WATCH = 4,
  parameter int PREG_W    = 7,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_WATCH-1:0][ARCH_REG_W-1:0]  watch_idx,
  input  logic                                  dump_req,
  input  logic                                  mispredict,
  output logic [ARCH_REG_W-1:0]                 map_raddr,
  input  logic [PREG_W-1:0]                     map_rdata,
  output logic [PREG_W-1:0]                     prf_raddr,
  input  logic [DATA_W-1:0]                     prf_rdata,
  output logic                                  rec_valid,
  input  logic                                  rec_ready,
  output logic [ARCH_REG_W-1:0]                 rec_areg,
  output logic [PREG_W-1:0]                     rec_preg,
  output logic [DATA_W-1:0]                     rec_data,
  output logic [CNT_W-1:0]                      rec_tag,
  output logic                                  rec_last,
  output logic [CNT_W-1:0]                      mispred_cnt,
  output logic                                  busy
);

  localparam int CH_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_WATCH - 1);

  state_t          state, state_nxt;
  logic [CH_W-1:0] ch, ch_nxt;
  logic            pending, pending_nxt;
  dump_rec_t       rec, rec_nxt;
  logic            trigger;

`ifdef ARCH_DUMP_MISPRED_TRIG_EN
  assign trigger = dump_req | mispredict;
`else
  assign trigger = dump_req;
`endif

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .cnt   (mispred_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ch      <= '0;
      pending <= 1'b0;
      rec     <= '0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      pending <= pending_nxt;
      rec     <= rec_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    rec_nxt     = rec;
    map_raddr   = '0;
    prf_raddr   = '0;
    // Any trigger seen in IDLE is consumed there; triggers while busy merge into one pending dump.
    pending_nxt = (state == IDLE) ? 1'b0 : (pending | trigger);
    case (state)
      IDLE: begin
        if (trigger || pending) begin
          rec_nxt.tag = REC_TAG_W'(mispred_cnt);
          ch_nxt      = '0;
          state_nxt   = MAP;
        end
      end
      MAP: begin
        map_raddr    = watch_idx[ch];
        rec_nxt.areg = watch_idx[ch];
        rec_nxt.preg = REC_PREG_W'(map_rdata);
        rec_nxt.last = (ch == LAST_CH);
        state_nxt    = PRF;
      end
      PRF: begin
        prf_raddr    = PREG_W'(rec.preg);
        rec_nxt.data = REC_DATA_W'(prf_rdata);
        state_nxt    = SEND;
      end
      SEND: begin
        if (rec_ready) begin
          if (ch == LAST_CH) begin
            state_nxt = IDLE;
          end else begin
            ch_nxt    = ch + CH_W'(1);
            state_nxt = MAP;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rec_valid = (state == SEND);
  assign rec_last  = (state == SEND) && rec.last;
  assign busy      = (state != IDLE);
  assign rec_areg  = rec.areg;
  assign rec_preg  = PREG_W'(rec.preg);
  assign rec_data  = DATA_W'(rec.data);
  assign rec_tag   = CNT_W'(rec.tag);

endmodule

// File: tb/tb_arch_dump_unit.sv
// tb/tb_arch_dump_unit.sv - directed self-checking bench for arch_dump_unit
module tb_arch_dump_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0][4:0]   watch_idx;
  logic              dump_req;
  logic              mispredict;
  logic              rec_ready;

  logic [4:0]  map_raddr;
  logic [6:0]  map_rdata;
  logic [6:0]  prf_raddr;
  logic [31:0] prf_rdata;
  logic        rec_valid;
  logic [4:0]  rec_areg;
  logic [6:0]  rec_preg;
  logic [31:0] rec_data;
  logic [15:0] rec_tag;
  logic        rec_last;
  logic [15:0] mispred_cnt;
  logic        busy;

  logic [4:0]  map_raddr4;
  logic [6:0]  map_rdata4;
  logic [6:0]  prf_raddr4;
  logic [31:0] prf_rdata4;
  logic        rec_valid4;
  logic [4:0]  rec_areg4;
  logic [6:0]  rec_preg4;
  logic [31:0] rec_data4;
  logic [3:0]  rec_tag4;
  logic        rec_last4;
  logic [3:0]  mispred_cnt4;
  logic        busy4;

  always #5 clk = ~clk;

  assign map_rdata  = (map_raddr == 5'd7) ? 7'd42 : (7'(map_raddr) + 7'd8);
  assign prf_rdata  = (prf_raddr == 7'd42) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(prf_raddr));
  assign map_rdata4 = 7'(map_raddr4);
  assign prf_rdata4 = 32'(prf_raddr4);

  arch_dump_unit dut (
    .clk(clk), .reset(reset), .watch_idx(watch_idx), .dump_req(dump_req),
    .mispredict(mispredict), .map_raddr(map_raddr), .map_rdata(map_rdata),
    .prf_raddr(prf_raddr), .prf_rdata(prf_rdata), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_areg(rec_areg), .rec_preg(rec_preg),
    .rec_data(rec_data), .rec_tag(rec_tag), .rec_last(rec_last),
    .mispred_cnt(mispred_cnt), .busy(busy)
  );

  arch_dump_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .watch_idx(watch_idx), .dump_req(dump_req),
    .mispredict(mispredict), .map_raddr(map_raddr4), .map_rdata(map_rdata4),
    .prf_raddr(prf_raddr4), .prf_rdata(prf_rdata4), .rec_valid(rec_valid4),
    .rec_ready(rec_ready), .rec_areg(rec_areg4), .rec_preg(rec_preg4),
    .rec_data(rec_data4), .rec_tag(rec_tag4), .rec_last(rec_last4),
    .mispred_cnt(mispred_cnt4), .busy(busy4)
  );

  typedef struct {
    logic [4:0]  areg;
    logic [6:0]  preg;
    logic [31:0] data;
    logic [15:0] tag;
    logic        last;
    int          cyc;
  } rec_s;

  rec_s q[$];
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (reset && rec_valid && rec_ready)
      q.push_back('{rec_areg, rec_preg, rec_data, rec_tag, rec_last, cyc_cnt});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      step(1);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  logic [4:0]  exp_areg [4] = '{5'd5, 5'd6, 5'd7, 5'd28};
  logic [6:0]  exp_preg [4] = '{7'd13, 7'd14, 7'd42, 7'd36};
  logic [31:0] exp_data [4] = '{32'h1000000D, 32'h1000000E, 32'hDEADBEEF, 32'h10000024};

  initial begin
    int          lat;
    int          lasts;
    logic [31:0] held_data;

    reset      = 1'b0;
    dump_req   = 1'b0;
    mispredict = 1'b0;
    rec_ready  = 1'b1;
    watch_idx[0] = 5'd5;
    watch_idx[1] = 5'd6;
    watch_idx[2] = 5'd7;
    watch_idx[3] = 5'd28;

    step(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(rec_valid), 64'd0);
    check("rst_map_raddr", 64'(map_raddr), 64'd0);
    check("rst_prf_raddr", 64'(prf_raddr), 64'd0);
    check("rst_cnt", 64'(mispred_cnt), 64'd0);
    check("rst_tag", 64'(rec_tag), 64'd0);
    check("rst_last", 64'(rec_last), 64'd0);
    reset = 1'b1;
    step(2);

    // Test 1: single dump, four ordered records
    q.delete();
    dump_req = 1'b1;
    step(1);
    dump_req = 1'b0;
    lat = 1;
    while (!rec_valid && lat < 20) begin
      step(1);
      lat++;
    end
    check("t1_first_valid_lat", 64'(lat), 64'd3);
    wait_idle("t1_idle", 40);
    check("t1_nrec", 64'(q.size()), 64'd4);
    if (q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_areg%0d", i), 64'(q[i].areg), 64'(exp_areg[i]));
        check($sformatf("t1_preg%0d", i), 64'(q[i].preg), 64'(exp_preg[i]));
        check($sformatf("t1_data%0d", i), 64'(q[i].data), 64'(exp_data[i]));
        check($sformatf("t1_last%0d", i), 64'(q[i].last), (i == 3) ? 64'd1 : 64'd0);
        check($sformatf("t1_tag%0d", i), 64'(q[i].tag), 64'd0);
      end
      check("t1_gap", 64'(q[1].cyc - q[0].cyc), 64'd3);
    end

    // Test 2: backpressure holds the record stable
    q.delete();
    rec_ready = 1'b0;
    dump_req  = 1'b1;
    step(1);
    dump_req = 1'b0;
    lat = 0;
    while (!rec_valid && lat < 20) begin
      step(1);
      lat++;
    end
    held_data = rec_data;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t2_valid_held", 64'(rec_valid), 64'd1);
      check("t2_areg_held", 64'(rec_areg), 64'd5);
      check("t2_data_held", 64'(rec_data), 64'(held_data));
    end
    check("t2_data_val", 64'(held_data), 64'h1000000D);
    check("t2_no_hs", 64'(q.size()), 64'd0);
    rec_ready = 1'b1;
    wait_idle("t2_idle", 40);
    check("t2_nrec", 64'(q.size()), 64'd4);

    // Test 3: triggers while busy merge into one extra dump
    q.delete();
    dump_req = 1'b1;
    step(1);
    dump_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(2);
      dump_req = 1'b1;
      step(1);
      dump_req = 1'b0;
    end
    step(50);
    check("t3_nrec", 64'(q.size()), 64'd8);
    lasts = 0;
    foreach (q[i]) if (q[i].last) lasts++;
    check("t3_dumps", 64'(lasts), 64'd2);
    if (q.size() == 8) check("t3_restart_ch0", 64'(q[4].areg), 64'd5);

    // Test 6: asynchronous reset while in PRF
    q.delete();
    mispredict = 1'b1;
    step(1);
    mispredict = 1'b0;
    dump_req = 1'b1;
    step(1);
    dump_req = 1'b0;
    step(1);
    check("t6_busy_prf", 64'(busy), 64'd1);
    check("t6_cnt_pre", 64'(mispred_cnt), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_valid_rst", 64'(rec_valid), 64'd0);
    check("t6_prf_raddr_rst", 64'(prf_raddr), 64'd0);
    check("t6_preg_rst", 64'(rec_preg), 64'd0);
    check("t6_cnt_rst", 64'(mispred_cnt), 64'd0);
    step(2);
    reset = 1'b1;
    step(20);
    check("t6_no_rec", 64'(q.size()), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);

    // Test 5: mispredict as trigger (only with the macro)
    q.delete();
    for (int k = 0; k < 3; k++) begin
      mispredict = 1'b1;
      step(1);
      mispredict = 1'b0;
      step(20);
    end
    check("t5_cnt", 64'(mispred_cnt), 64'd3);
    check("t5_cnt4", 64'(mispred_cnt4), 64'd3);
`ifdef ARCH_DUMP_MISPRED_TRIG_EN
    check("t5_nrec", 64'(q.size()), 64'd12);
    if (q.size() == 12) begin
      check("t5_tag_first", 64'(q[0].tag), 64'd0);
      check("t5_tag_third", 64'(q[8].tag), 64'd2);
    end
`else
    check("t5_nrec", 64'(q.size()), 64'd0);
`endif

    // Test 4: 20 consecutive mispredicts, 4-bit counter saturates
    mispredict = 1'b1;
    step(20);
    mispredict = 1'b0;
    check("t4_cnt16", 64'(mispred_cnt), 64'd23);
    check("t4_cnt4_sat", 64'(mispred_cnt4), 64'd15);
    step(60);
    check("t4_cnt4_hold", 64'(mispred_cnt4), 64'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
